// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_e  : converter FSM states (idle, shifting, result load)
//   BCD_MAX  : largest value representable in four BCD digits
//   BCD_SAT  : packed-BCD word shown when a saturating build overflows
//   DIGIT_W  : bits per BCD digit
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   localparam int unsigned BCD_MAX = 9999;
   localparam logic [15:0] BCD_SAT = 16'h9999;
   localparam int unsigned DIGIT_W = 4;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a value producer and bin2bcd_seq.
//   start    : conversion request (producer -> converter)
//   bin      : unsigned binary value (producer -> converter)
//   busy     : converter not idle
//   done     : one-cycle pulse, bcd/overflow just updated
//   bcd      : packed BCD, digit 0 in [3:0]
//   overflow : last accepted bin exceeded 9999
// master = producer side, slave = converter side.
interface bin2bcd_seq_if #(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
);
   logic                  start;
   logic [BIN_W-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;

   modport master (
      output start, bin,
      input  busy, done, bcd, overflow
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd, overflow
   );
endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: adds 3 when the digit is 5 or more, so
// that the following left shift carries correctly into the next decade.
//   din  : BCD digit before correction
//   dout : corrected digit
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] din,
   output logic [DIGIT_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (din >= DIGIT_W'(5)) begin
         dout = din + DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// The bcd/overflow outputs only change when a conversion completes, so a
// display fed from bcd never shows partial results.
//   clk : system clock, rising edge
//   RST : synchronous active-low reset
//   bus : bin2bcd_seq_if.slave (start/bin in; busy/done/bcd/overflow out)
// Build option: BIN2BCD_SAT_EN -- when defined, an out-of-range input loads
// bcd with 9999 instead of the modulo-10000 value.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic          clk,
   input  logic          RST,
   bin2bcd_seq_if.slave  bus
);

   localparam int unsigned SCR_W = DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   shift_q, shift_d;
   logic [SCR_W-1:0]   scr_q, scr_d, scr_adj;
   logic [SCR_W-1:0]   bcd_q, bcd_d;
   logic               ovf_flag_q, ovf_flag_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adj u_adj (
         .din  (scr_q[g*DIGIT_W +: DIGIT_W]),
         .dout (scr_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      scr_d      = scr_q;
      bcd_d      = bcd_q;
      ovf_flag_d = ovf_flag_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               shift_d    = bus.bin;
               scr_d      = '0;
               cnt_d      = CNT_W'(BIN_W - 1);
               ovf_flag_d = (32'(bus.bin) > BCD_MAX);
               state_d    = StShift;
            end
         end
         StShift: begin
            // Carries out of the top digit fall off: result is bin mod 10^DIGITS.
            {scr_d, shift_d} = {scr_adj, shift_q} << 1;
            if (cnt_q == '0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StDone: begin
`ifdef BIN2BCD_SAT_EN
            bcd_d = ovf_flag_q ? SCR_W'(BCD_SAT) : scr_q;
`else
            bcd_d = scr_q;
`endif
            overflow_d = ovf_flag_q;
            done_d     = 1'b1;
            state_d    = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RST) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         scr_q      <= '0;
         bcd_q      <= '0;
         ovf_flag_q <= 1'b0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         scr_q      <= scr_d;
         bcd_q      <= bcd_d;
         ovf_flag_q <= ovf_flag_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   // done is registered so it rises in the first idle cycle, as busy falls.
   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random values
// compared against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

   logic clk;
   logic RST;
   int   n_total;
   int   n_pass;

   bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

   bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
      .clk (clk),
      .RST (RST),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Expected packed BCD from plain decimal arithmetic.
   function automatic logic [15:0] model_bcd(input int v);
      int m;
      m = v % 10000;
`ifdef BIN2BCD_SAT_EN
      if (v > 9999) m = 9999;
`endif
      return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic start_conv(input int v);
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = 14'(v);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // lat = rising edges from the call point until done is seen (-1 if never).
   task automatic wait_done(input int budget, output int lat, output bit held);
      logic [15:0] b0;
      b0   = bus.bcd;
      lat  = -1;
      held = 1'b1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = k;
            break;
         end
         if (bus.bcd !== b0) held = 1'b0;
      end
   endtask

   task automatic no_done(input int n, input string tag);
      int cnt;
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.done) cnt++;
      end
      check(tag, cnt, 0);
   endtask

   task automatic convert(input int v, input string tag);
      int lat;
      bit held;
      start_conv(v);
      check({tag, " busy"}, bus.busy, 1);
      wait_done(40, lat, held);
      check({tag, " latency"}, lat, 15);
      check({tag, " held"}, held, 1);
      check({tag, " bcd"}, bus.bcd, model_bcd(v));
      check({tag, " ovf"}, bus.overflow, (v > 9999) ? 1 : 0);
      check({tag, " busy_low"}, bus.busy, 0);
      @(negedge clk);
      check({tag, " done_pulse"}, bus.done, 0);
   endtask

   initial begin
      int lat;
      bit held;
      n_total   = 0;
      n_pass    = 0;
      bus.start = 1'b0;
      bus.bin   = '0;
      RST       = 1'b0;
      repeat (3) @(negedge clk);
      RST = 1'b1;

      check("rst bcd", bus.bcd, 16'h0000);
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst ovf", bus.overflow, 0);

      convert(1234, "c1234");
      convert(0, "c0");
      convert(9999, "c9999");
      convert(12345, "c12345");
      convert(16383, "cmax");

      // start during SHIFT is ignored
      start_conv(42);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = 14'd7777;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(40, lat, held);
      check("ign latency", lat, 10);
      check("ign bcd", bus.bcd, 16'h0042);
      no_done(20, "ign no_second_done");
      check("ign bcd_after", bus.bcd, 16'h0042);

      // reset aborts an in-flight conversion
      convert(1234, "pre_rst");
      start_conv(5678);
      repeat (6) @(negedge clk);
      RST = 1'b0;
      @(negedge clk);
      RST = 1'b1;
      check("abort bcd", bus.bcd, 16'h0000);
      check("abort busy", bus.busy, 0);
      check("abort ovf", bus.overflow, 0);
      no_done(20, "abort no_done");
      convert(5678, "c5678");

      // start held high: back-to-back conversions every 16 cycles
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = 14'd321;
      @(negedge clk);
      wait_done(40, lat, held);
      check("hold first_lat", lat, 15);
      check("hold bcd0", bus.bcd, 16'h0321);
      for (int i = 0; i < 2; i++) begin
         wait_done(40, lat, held);
         check("hold period", lat, 16);
         check("hold bcd", bus.bcd, 16'h0321);
      end
      bus.start = 1'b0;
      no_done(20, "hold stop");

      for (int i = 0; i < 20; i++) begin
         convert(int'($urandom_range(16383, 0)), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display driver. It takes a 14-bit binary value (score, floor count, timer) and produces the 16-bit packed-BCD word the display driver consumes on its `HEXS` input. Conversion uses shift-and-add-3 (double dabble), one bit per clock, with a start/done handshake. The output register holds its last value during conversion so the display never shows partial results.

## Interface
- `BIN_W`, 14: binary input width; fixed range 1..14.
- `DIGITS`, 4: BCD digits produced; fixed at 4 to match the display driver.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset; synchronous, active-low.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin`  in  BIN_W  unsigned binary value; captured on the accepting edge.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse: `bcd` has just been updated.
- `bcd`  out  4*DIGITS  packed BCD, digit 0 in [3:0]; drives the display `HEXS`.
- `overflow`  out  1  set when the last accepted `bin` exceeded 9999.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on `start`=1, capture `bin` into shift register, clear the BCD scratch, load bit counter with BIN_W-1, go to SHIFT. Evaluate `bin` > 9999 and latch into an internal overflow flag.
- SHIFT, once per cycle: every scratch digit >= 5 gets +3, then shift {scratch, binary} left by one. At counter = 0 go to DONE; otherwise decrement.
- DONE: copy scratch (or the saturated value, see Configuration) into `bcd`, copy the overflow flag to `overflow`, pulse `done`, return to IDLE.
- `start` in SHIFT or DONE is ignored; it is not queued.
- Scratch is exactly 4*DIGITS bits. Carries out of the top digit are discarded, so the raw result equals `bin` mod 10000.
- `bcd` and `overflow` change only in DONE. Between conversions they hold their values.
- Reset at any time: state IDLE, counter 0, scratch 0, `bcd`=16'h0000, `done`=0, `busy`=0, `overflow`=0. An in-flight conversion is aborted and produces no `done`.

## Timing
- Accepting edge E0 (IDLE, `start`=1). SHIFT occupies edges E1..E_BIN_W. DONE is entered after edge E_BIN_W.
- `bcd`, `overflow` and `done` are updated at edge E_BIN_W+1. Latency is BIN_W+1 = 15 cycles for the default width.
- `done` is high for exactly one cycle, E_BIN_W+1 to E_BIN_W+2.
- `busy` is high from E0 until E_BIN_W+1. It falls in the same cycle `done` rises.
- The earliest next accept is edge E_BIN_W+2. That gives back-to-back throughput of one conversion per BIN_W+2 cycles.
- `start` held high continuously restarts immediately after each DONE.

## Configuration
- `BIN2BCD_SAT_EN` defined: if the overflow flag is set, DONE loads `bcd` with 16'h9999 instead of the scratch value.
- `BIN2BCD_SAT_EN` undefined: `bcd` gets the modulo-10000 result.
- `overflow` is reported identically in both builds.

## Structure
- Package `bin2bcd_pkg`:
  - state encoding (IDLE, SHIFT, DONE)
  - `BCD_MAX` = 9999
  - `BCD_SAT` = 16'h9999
  - digit-width constant of 4
- Sub-module `bcd_digit_adj`: combinational 4-bit "add 3 if >= 5". Instantiated DIGITS times in a generate loop.
- Everything else lives in `bin2bcd_seq`: FSM, counter, shift register, output register.

## Test plan
- Reset, then `bin`=1234 with `start` pulsed at E0 -> `busy` high; `done` at E15; `bcd`=16'h1234; `overflow`=0.
- `bin`=0, then `bin`=9999 -> `bcd`=16'h0000, then 16'h9999; `overflow`=0 both times.
- `bin`=12345: with `BIN2BCD_SAT_EN` -> `bcd`=16'h9999, `overflow`=1. Without it -> `bcd`=16'h2345, `overflow`=1.
- Converting 0042, pulse `start` with `bin`=7777 at E5 -> result 16'h0042; no second `done`; 7777 never appears.
- Previous `bcd`=16'h1234, start 5678, deassert `RST` at E7 for one cycle -> `bcd`=16'h0000, `busy`=0, no `done`. A new start of 5678 then yields 16'h5678 after 15 cycles.
- `start` held high with `bin`=0321 -> `done` pulses every 16 cycles; `bcd` stays 16'h0321.
